relu_backward_gate: RTL
=======================

// Module: relu_backward_gate
// PURPOSE
//  Backward-pass counterpart of the ReLU activation stage. Forward pass: records one
//  derivative bit per neuron from the 21-bit pre-activation (1 if sign bit is 0, i.e. >= 0).
//  Backward pass: gates the incoming error gradient per neuron; passes it when the bit is 1,
//  outputs 0 when it is 0. Sits between the next layer's error path and this layer's
//  weight-update logic. Handles one layer (DEPTH neurons) per forward/backward pair.
// PARAMETERS
//  DATA_W  21  pre-activation / gradient width, two's complement
//  DEPTH   16  neurons per layer = mask bits stored (>= 2)
//  IDX_W   4   index width, = clog2(DEPTH)
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       reset, asynchronous, active-low
//  clear       in   1       sync abort: discards mask and returns to CAPTURE
//  fwd_valid   in   1       pre-activation sample valid
//  fwd_ready   out  1       block accepts a pre-activation
//  fwd_preact  in   DATA_W  pre-activation, neuron order 0..DEPTH-1
//  bwd_valid   in   1       gradient valid
//  bwd_ready   out  1       block accepts a gradient
//  bwd_grad    in   DATA_W  dL/d(activation), neuron order 0..DEPTH-1
//  out_valid   out  1       gated gradient valid
//  out_ready   in   1       downstream accepts gated gradient
//  out_grad    out  DATA_W  gated gradient dL/d(preact)
//  mask_cnt    out  IDX_W+1 bits captured in the current layer (0..DEPTH)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=CAPTURE, idx=0, mask=0, mask_cnt=0, out_valid=0,
//   out_grad=0, fwd_ready=1, bwd_ready=0.
//  A transfer occurs on a rising edge when valid && ready (applies to fwd, bwd and out).
//  States:
//   CAPTURE: fwd_ready=1, bwd_ready=0. On each fwd transfer: mask[idx] <= ~fwd_preact[DATA_W-1],
//    idx++, mask_cnt++. The transfer at idx==DEPTH-1 goes to GATE with idx=0 and mask_cnt=DEPTH.
//   GATE: fwd_ready=0. bwd_ready = !out_valid || out_ready (1-entry output register; full
//    throughput under continuous out_ready). On a bwd transfer:
//    out_grad <= mask[idx] ? bwd_grad : 0; out_valid <= 1; idx++.
//    The transfer at idx==DEPTH-1 goes to DRAIN.
//   DRAIN: bwd_ready=0. Waits until the last out transfer, then -> CAPTURE, idx=0, mask_cnt=0.
//    If out_valid is already 0, the change happens on the next edge.
//  out_valid clears on an out transfer unless a new bwd transfer occurs on the same edge.
//  out_grad/out_valid hold stable while out_valid && !out_ready.
//  Latency: bwd transfer -> out_valid high on the next cycle (1 cycle). Output is registered;
//   no combinational path bwd_grad -> out_grad.
//  Width: no arithmetic. The gradient is passed bit-exact or forced to all-zero.
//   Zero pre-activation gives mask=1, which matches forward ReLU (0 passes through).
//  Boundaries:
//   - fwd_valid in GATE/DRAIN: ignored (ready low); bwd_valid in CAPTURE: ignored.
//   - Index wrap: idx never exceeds DEPTH-1. Handled by the state change, not modulo.
//   - clear (sync, highest priority after rst_n): state=CAPTURE, idx=0, mask_cnt=0,
//     out_valid=0 on that edge. Transfers on the same edge are discarded.
//     mask contents need not be zeroed.
//   - Reset/clear mid-layer: the partial mask is lost; the next fwd sample is neuron 0.
// STRUCTURE
//  Shared package: DATA_W, DEPTH, IDX_W defaults (common with the activation and neuron
//   blocks); state encoding localparams ST_CAPTURE=2'd0, ST_GATE=2'd1, ST_DRAIN=2'd2.
//  The DEPTH-bit mask is flops, not RAM.
//  One sub-module: relu_grad_outreg. It holds the 1-entry valid/ready output register and
//   produces the ready signal for upstream.
// TESTING
//  1) Reset, DEPTH=16, feed preacts alternating +5 (0x000005) / -5 (0x1FFFFB), then grads
//     all 0x000100 with out_ready=1 -> out_grad = 0x100,0,0x100,0,...; mask_cnt reaches 16.
//  2) preact=0 for neuron 3, grad 0x0ABCDE -> out_grad for neuron 3 = 0x0ABCDE.
//     preact 0x100000 (most negative) -> 0.
//  3) Backpressure: out_ready=0 for 5 cycles mid-GATE -> bwd_ready low after 1 accepted;
//     out_grad stable; no loss or duplication; all 16 outputs in order.
//  4) fwd_valid held high during GATE and bwd_valid high during CAPTURE -> no extra
//     captures/outputs; mask_cnt stays 16 in GATE.
//  5) clear after 7 captures -> mask_cnt=0 next cycle; 16 new preacts then gate correctly.
//     clear in GATE with out_valid=1 -> out_valid=0 next cycle.
//  6) rst_n pulsed low asynchronously mid-GATE (between edges) -> outputs at reset values
//     immediately; after release, a full layer passes.
//     Back-to-back layers: the second CAPTURE starts right after DRAIN.

Source files
------------

// File: rtl/relu_backward_gate_pkg.sv
// Shared layer geometry and FSM encoding for the ReLU backward gate and its
// neighbouring activation/neuron blocks.
package relu_backward_gate_pkg;

    localparam int unsigned DATA_W = 21;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned IDX_W  = 4;

    localparam logic [1:0] ST_CAPTURE = 2'd0;
    localparam logic [1:0] ST_GATE    = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    typedef enum logic [1:0] {
        StCapture = ST_CAPTURE,
        StGate    = ST_GATE,
        StDrain   = ST_DRAIN
    } state_e;

    // ReLU derivative: 1 for non-negative (sign bit clear), so zero passes.
    function automatic logic relu_deriv(input logic sign_bit);
        return ~sign_bit;
    endfunction

endpackage

// File: rtl/relu_grad_outreg.sv
// One-entry valid/ready output register for the gated gradient; also produces the
// upstream ready so the stage keeps full throughput under continuous downstream ready.
module relu_grad_outreg
    import relu_backward_gate_pkg::*;
#(
    parameter int unsigned DataW = DATA_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             in_valid_i,
    input  logic [DataW-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DataW-1:0] out_data_o
);

    logic             valid_q, valid_d;
    logic [DataW-1:0] data_q, data_d;
    logic             load;

    assign in_ready_o = !valid_q || out_ready_i;
    assign load       = in_valid_i && in_ready_o;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/relu_backward_gate.sv
// ReLU backward gate: captures one derivative bit per neuron in the forward pass, then
// passes or zeroes each incoming error gradient in the backward pass, one layer at a time.
module relu_backward_gate
    import relu_backward_gate_pkg::*;
#(
    parameter int unsigned DataW = DATA_W,
    parameter int unsigned Depth = DEPTH,
    parameter int unsigned IdxW  = IDX_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             fwd_valid_i,
    output logic             fwd_ready_o,
    input  logic [DataW-1:0] fwd_preact_i,
    input  logic             bwd_valid_i,
    output logic             bwd_ready_o,
    input  logic [DataW-1:0] bwd_grad_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DataW-1:0] out_grad_o,
    output logic [IdxW:0]    mask_cnt_o
);

    localparam int unsigned CntW = IdxW + 1;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [Depth-1:0]  mask_q, mask_d;

    logic              in_gate;
    logic              idx_last;
    logic              fwd_fire;
    logic              bwd_fire;
    logic              outreg_ready;
    logic [DataW-1:0]  gated_grad;

    assign in_gate     = (state_q == StGate);
    assign idx_last    = (idx_q == IdxW'(Depth - 1));
    assign fwd_ready_o = (state_q == StCapture);
    assign bwd_ready_o = in_gate && outreg_ready;
    assign fwd_fire    = fwd_valid_i && fwd_ready_o;
    assign bwd_fire    = bwd_valid_i && bwd_ready_o;
    assign gated_grad  = mask_q[idx_q] ? bwd_grad_i : '0;
    assign mask_cnt_o  = cnt_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        if (clear_i) begin
            // Mask bits are left stale; they are rewritten before the next gate pass.
            state_d = StCapture;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StCapture: begin
                    if (fwd_fire) begin
                        mask_d[idx_q] = relu_deriv(fwd_preact_i[DataW-1]);
                        cnt_d         = cnt_q + CntW'(1);
                        if (idx_last) begin
                            idx_d   = '0;
                            state_d = StGate;
                        end else begin
                            idx_d = idx_q + IdxW'(1);
                        end
                    end
                end
                StGate: begin
                    if (bwd_fire) begin
                        if (idx_last) begin
                            idx_d   = '0;
                            state_d = StDrain;
                        end else begin
                            idx_d = idx_q + IdxW'(1);
                        end
                    end
                end
                StDrain: begin
                    // Leave on the edge that retires the last gated gradient.
                    if (!out_valid_o || out_ready_i) begin
                        state_d = StCapture;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = StCapture;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StCapture;
            idx_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
        end
    end

    relu_grad_outreg #(
        .DataW (DataW)
    ) u_outreg (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .in_valid_i  (bwd_valid_i && in_gate),
        .in_data_i   (gated_grad),
        .in_ready_o  (outreg_ready),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_grad_o)
    );

endmodule
